white_key_tracker: RTL and testbench

WHITE_KEY_TRACKER -- requirements
Module: white_key_tracker

---
 rtl/white_key_tracker_pkg.sv | 18 +
 rtl/key_event_hold.sv | 63 ++++++
 rtl/white_key_tracker.sv | 126 ++++++++++++
 tb/tb_white_key_tracker.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/white_key_tracker_pkg.sv
// Shared display constants for the white-key overlay: default keyboard geometry
// and the per-line tracker state encoding.
package white_key_tracker_pkg;

   localparam int WHITE_X_OFF_DEF = 11;
   localparam int KEY_PITCH_DEF   = 24;
   localparam int NUM_KEYS_DEF    = 15;
   localparam int X_W             = 12;
   localparam int IDX_W           = 4;

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_PRE  = 2'd1,
      ST_KEY  = 2'd2,
      ST_DONE = 2'd3
   } trk_state_t;

endpackage

// File: rtl/key_event_hold.sv
// One-deep key event holding register plus pressed bitmap; events land on the bitmap only at line_start.
// note_ready is low while an event is held; a coincident line_start and event on an empty register captures it.
module key_event_hold
   import white_key_tracker_pkg::*;
#(
   parameter int NUM_KEYS = NUM_KEYS_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               line_start,
   input  logic               note_valid,
   output logic               note_ready,
   input  logic [IDX_W-1:0]   note_idx,
   input  logic               note_on,
   output logic [NUM_KEYS-1:0] bitmap
);

   logic                hold_vld_q, hold_vld_d;
   logic [IDX_W-1:0]    hold_idx_q, hold_idx_d;
   logic                hold_on_q, hold_on_d;
   logic [NUM_KEYS-1:0] bitmap_q, bitmap_d;
   logic                accept;

   assign note_ready = ~hold_vld_q;
   assign accept     = note_valid & ~hold_vld_q;
   assign bitmap     = bitmap_q;

   always_comb begin
      hold_vld_d = hold_vld_q;
      hold_idx_d = hold_idx_q;
      hold_on_d  = hold_on_q;
      bitmap_d   = bitmap_q;
      if (line_start && hold_vld_q) begin
         // Out-of-range indices match no bit and are silently dropped here.
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (hold_idx_q == IDX_W'(i)) begin
               bitmap_d[i] = hold_on_q;
            end
         end
         hold_vld_d = 1'b0;
      end
      if (accept) begin
         hold_vld_d = 1'b1;
         hold_idx_d = note_idx;
         hold_on_d  = note_on;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_vld_q <= 1'b0;
         hold_idx_q <= '0;
         hold_on_q  <= 1'b0;
         bitmap_q   <= '0;
      end else begin
         hold_vld_q <= hold_vld_d;
         hold_idx_q <= hold_idx_d;
         hold_on_q  <= hold_on_d;
         bitmap_q   <= bitmap_d;
      end
   end

endmodule

// File: rtl/white_key_tracker.sv
// Classifies each pixel X into a white key (index, shared-edge flag, pressed state); outputs registered, latency 1.
// Key events are accepted through a one-deep valid/ready holding register and applied at line_start.
module white_key_tracker
   import white_key_tracker_pkg::*;
#(
   parameter int WHITE_X_OFF = WHITE_X_OFF_DEF,
   parameter int KEY_PITCH   = KEY_PITCH_DEF,
   parameter int NUM_KEYS    = NUM_KEYS_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [X_W-1:0]   CounterX,
   input  logic             pixel_en,
   input  logic             line_start,
   input  logic             note_valid,
   output logic             note_ready,
   input  logic [IDX_W-1:0] note_idx,
   input  logic             note_on,
   output logic             key_valid,
   output logic [IDX_W-1:0] key_idx,
   output logic             key_edge,
   output logic             key_pressed
);

   localparam logic [X_W-1:0]   X_OFF   = X_W'(WHITE_X_OFF);
   localparam logic [X_W-1:0]   HI0     = X_W'(WHITE_X_OFF + KEY_PITCH);
   localparam logic [X_W-1:0]   PITCH   = X_W'(KEY_PITCH);
   localparam logic [IDX_W-1:0] IDX_LST = IDX_W'(NUM_KEYS - 1);

   trk_state_t          state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [X_W-1:0]      hi_q, hi_d;
   logic                key_valid_q, key_valid_d;
   logic [IDX_W-1:0]    key_idx_q, key_idx_d;
   logic                key_edge_q, key_edge_d;
   logic                key_pressed_q, key_pressed_d;
   logic                cls_vld;
   logic [IDX_W-1:0]    cls_idx;
   logic [X_W-1:0]      cls_hi;
   logic [NUM_KEYS-1:0] bitmap;

   key_event_hold #(.NUM_KEYS(NUM_KEYS)) u_hold (
      .clk        (clk),
      .reset_n    (reset_n),
      .line_start (line_start),
      .note_valid (note_valid),
      .note_ready (note_ready),
      .note_idx   (note_idx),
      .note_on    (note_on),
      .bitmap     (bitmap)
   );

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      hi_d          = hi_q;
      key_valid_d   = key_valid_q;
      key_idx_d     = key_idx_q;
      key_edge_d    = key_edge_q;
      key_pressed_d = key_pressed_q;
      cls_vld       = 1'b0;
      cls_idx       = idx_q;
      cls_hi        = hi_q;
      if (line_start) begin
         state_d = ST_PRE;
         idx_d   = '0;
         hi_d    = HI0;
      end else if (pixel_en) begin
         case (state_q)
            ST_PRE: begin
               if (CounterX >= X_OFF) begin
                  state_d = ST_KEY;
                  cls_vld = 1'b1;
               end
            end
            ST_KEY: begin
               // Step to the next key once X passes the accumulated upper bound.
               if (CounterX > hi_q) begin
                  if (idx_q == IDX_LST) begin
                     state_d = ST_DONE;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     hi_d    = hi_q + PITCH;
                     cls_vld = 1'b1;
                     cls_idx = idx_d;
                     cls_hi  = hi_d;
                  end
               end else begin
                  cls_vld = 1'b1;
               end
            end
            default: ;
         endcase
         key_valid_d   = cls_vld;
         key_idx_d     = cls_vld ? cls_idx : '0;
         key_edge_d    = cls_vld && (CounterX == cls_hi) && (cls_idx != IDX_LST);
         key_pressed_d = cls_vld && bitmap[cls_idx];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_WAIT;
         idx_q         <= '0;
         hi_q          <= HI0;
         key_valid_q   <= 1'b0;
         key_idx_q     <= '0;
         key_edge_q    <= 1'b0;
         key_pressed_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         hi_q          <= hi_d;
         key_valid_q   <= key_valid_d;
         key_idx_q     <= key_idx_d;
         key_edge_q    <= key_edge_d;
         key_pressed_q <= key_pressed_d;
      end
   end

   assign key_valid   = key_valid_q;
   assign key_idx     = key_idx_q;
   assign key_edge    = key_edge_q;
   assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_white_key_tracker.sv
// Directed bench for white_key_tracker: geometry, event timing, discard and reset behaviour.
module tb_white_key_tracker;
   import white_key_tracker_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [11:0] CounterX = '0;
   logic        pixel_en = 1'b0;
   logic        line_start = 1'b0;
   logic        note_valid = 1'b0;
   logic [3:0]  note_idx = '0;
   logic        note_on = 1'b0;
   logic        note_ready;
   logic        key_valid;
   logic [3:0]  key_idx;
   logic        key_edge;
   logic        key_pressed;

   int total = 0;
   int bad   = 0;

   white_key_tracker dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .CounterX    (CounterX),
      .pixel_en    (pixel_en),
      .line_start  (line_start),
      .note_valid  (note_valid),
      .note_ready  (note_ready),
      .note_idx    (note_idx),
      .note_on     (note_on),
      .key_valid   (key_valid),
      .key_idx     (key_idx),
      .key_edge    (key_edge),
      .key_pressed (key_pressed)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic px(input int x);
      CounterX = 12'(x);
      pixel_en = 1'b1;
      @(posedge clk);
      #1;
      pixel_en = 1'b0;
   endtask

   task automatic ls();
      line_start = 1'b1;
      @(posedge clk);
      #1;
      line_start = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_kv", key_valid, 0);
      check_val("rst_ki", key_idx, 0);
      check_val("rst_ke", key_edge, 0);
      check_val("rst_kp", key_pressed, 0);
      check_val("rst_bmp", dut.u_hold.bitmap_q, 0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check_val("rst_rdy", note_ready, 1);
      check_val("rst_st", dut.state_q, ST_WAIT);
      px(11);
      check_val("wait_kv", key_valid, 0);

      // line_start with a coincident pixel: pixel ignored
      line_start = 1'b1;
      pixel_en   = 1'b1;
      CounterX   = 12'd11;
      @(posedge clk);
      #1;
      line_start = 1'b0;
      pixel_en   = 1'b0;
      check_val("ls_pix_kv", key_valid, 0);
      check_val("ls_pix_st", dut.state_q, ST_PRE);

      // line 1: geometry, plus press key 3 mid-line and a blocked second event
      for (int x = 0; x <= 400; x++) begin
         if (x == 200) begin
            note_valid = 1'b1; note_idx = 4'd3; note_on = 1'b1;
         end
         if (x == 201) note_idx = 4'd5;
         px(x);
         case (x)
            10:  check_val("x10_kv", key_valid, 0);
            11:  begin check_val("x11_kv", key_valid, 1); check_val("x11_ki", key_idx, 0); end
            35:  begin check_val("x35_ki", key_idx, 0); check_val("x35_ke", key_edge, 1); end
            36:  begin check_val("x36_ki", key_idx, 1); check_val("x36_ke", key_edge, 0); end
            59:  begin check_val("x59_ki", key_idx, 1); check_val("x59_ke", key_edge, 1); end
            200: check_val("ev1_rdy", note_ready, 0);
            371: begin
               check_val("x371_kv", key_valid, 1);
               check_val("x371_ki", key_idx, 14);
               check_val("x371_ke", key_edge, 0);
            end
            372: begin check_val("x372_kv", key_valid, 0); check_val("x372_st", dut.state_q, ST_DONE); end
            400: begin check_val("l1_bmp", dut.u_hold.bitmap_q, 0); check_val("l1_rdy", note_ready, 0); end
            default: ;
         endcase
      end

      // line 2: key 3 applied; blocked event (key 5) now accepted
      ls();
      check_val("l2_rdy", note_ready, 1);
      check_val("l2_bmp", dut.u_hold.bitmap_q, 15'h0008);
      px(0);
      check_val("ev2_rdy", note_ready, 0);
      note_valid = 1'b0;
      for (int x = 1; x <= 400; x++) begin
         px(x);
         case (x)
            82:  check_val("l2_x82_kp", key_pressed, 0);
            84:  begin check_val("l2_x84_kp", key_pressed, 1); check_val("l2_x84_ki", key_idx, 3); end
            107: begin
               check_val("l2_x107_kp", key_pressed, 1);
               check_val("l2_x107_ke", key_edge, 1);
            end
            108: begin check_val("l2_x108_kp", key_pressed, 0); check_val("l2_x108_ki", key_idx, 4); end
            132: check_val("l2_x132_kp", key_pressed, 0);
            default: ;
         endcase
      end

      // line 3: key 5 applied; send out-of-range index 15
      ls();
      check_val("l3_bmp", dut.u_hold.bitmap_q, 15'h0028);
      for (int x = 0; x <= 400; x++) begin
         if (x == 50) begin
            note_valid = 1'b1; note_idx = 4'd15; note_on = 1'b1;
         end
         if (x == 51) note_valid = 1'b0;
         px(x);
         case (x)
            50:  check_val("oor_rdy", note_ready, 0);
            132: begin check_val("l3_x132_kp", key_pressed, 1); check_val("l3_x132_ki", key_idx, 5); end
            155: check_val("l3_x155_kp", key_pressed, 1);
            156: check_val("l3_x156_kp", key_pressed, 0);
            default: ;
         endcase
      end

      ls();
      check_val("oor_bmp", dut.u_hold.bitmap_q, 15'h0028);
      check_val("oor_rdy2", note_ready, 1);
      for (int x = 0; x <= 400; x++) px(x);

      // event coincident with line_start on an empty register: release key 3
      note_valid = 1'b1; note_idx = 4'd3; note_on = 1'b0;
      ls();
      note_valid = 1'b0;
      check_val("co_rdy", note_ready, 0);
      check_val("co_bmp", dut.u_hold.bitmap_q, 15'h0028);
      for (int x = 0; x <= 120; x++) begin
         px(x);
         if (x == 90) check_val("co_x90_kp", key_pressed, 1);
      end
      ls();
      check_val("co_bmp2", dut.u_hold.bitmap_q, 15'h0020);
      check_val("co_rdy2", note_ready, 1);

      // reset mid-line with an event pending
      for (int x = 0; x <= 200; x++) begin
         if (x == 150) begin
            note_valid = 1'b1; note_idx = 4'd7; note_on = 1'b1;
         end
         if (x == 151) note_valid = 1'b0;
         px(x);
         if (x == 90) check_val("l6_x90_kp", key_pressed, 0);
      end
      reset_n = 1'b0;
      #1;
      check_val("mr_kv", key_valid, 0);
      check_val("mr_ki", key_idx, 0);
      check_val("mr_ke", key_edge, 0);
      check_val("mr_kp", key_pressed, 0);
      check_val("mr_bmp", dut.u_hold.bitmap_q, 0);
      check_val("mr_st", dut.state_q, ST_WAIT);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check_val("mr_rdy", note_ready, 1);
      for (int x = 0; x <= 60; x++) begin
         px(x);
         if (x == 11) check_val("mr_x11_kv", key_valid, 0);
         if (x == 50) check_val("mr_x50_kv", key_valid, 0);
      end
      ls();
      check_val("mr_bmp2", dut.u_hold.bitmap_q, 0);
      for (int x = 0; x <= 100; x++) begin
         px(x);
         if (x == 11) check_val("mr2_x11_kv", key_valid, 1);
         if (x == 90) begin
            check_val("mr2_x90_ki", key_idx, 3);
            check_val("mr2_x90_kp", key_pressed, 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
